// File: rtl/muldiv_fu_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_fu_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } muldiv_state_t;

    function automatic logic op_is_div(muldiv_op_t op);
        return op inside {OpDiv, OpDivu, OpRem, OpRemu};
    endfunction

    function automatic logic rs1_signed(muldiv_op_t op);
        return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    endfunction

    function automatic logic rs2_signed(muldiv_op_t op);
        return op inside {OpMul, OpMulh, OpDiv, OpRem};
    endfunction

endpackage

// File: rtl/muldiv_fu_step.sv
// One iteration of the unit: MSB-first shift-add multiply or restoring-divide step.
module muldiv_fu_step
    import muldiv_fu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              is_div_i,
    input  logic              mbit_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   rem_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic [XLEN-1:0]   rem_o
);

    logic [XLEN:0] part_rem;
    logic [XLEN:0] diff;
    logic          q_bit;

    always_comb begin
        // acc low half holds the dividend being shifted out and the quotient being shifted in
        part_rem = {rem_i, acc_i[XLEN-1]};
        diff     = part_rem - {1'b0, opnd_i};
        q_bit    = ~diff[XLEN];
        if (is_div_i) begin
            acc_o = {{XLEN{1'b0}}, acc_i[XLEN-2:0], q_bit};
            rem_o = q_bit ? diff[XLEN-1:0] : part_rem[XLEN-1:0];
        end else begin
            acc_o = {acc_i[2*XLEN-2:0], 1'b0} + (mbit_i ? {{XLEN{1'b0}}, opnd_i} : '0);
            rem_o = rem_i;
        end
    end

endmodule

// File: rtl/muldiv_fu.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, result pulsed once on the CDB mul_* fields.
// Define MULDIV_FASTPATH_EN to retire div-by-zero, signed overflow and zero-operand multiplies from IDLE.
module muldiv_fu
    import muldiv_fu_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ROB_IDX_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    input  logic [2:0]               in_op_i,
    input  logic [XLEN-1:0]          in_rs1_i,
    input  logic [XLEN-1:0]          in_rs2_i,
    input  logic [4:0]               in_rd_addr_i,
    input  logic [ROB_IDX_WIDTH-1:0] in_rob_idx_i,
    output logic                     ready_o,
    output logic                     out_valid_o,
    output logic [XLEN-1:0]          out_data_o,
    output logic [4:0]               out_rd_addr_o,
    output logic [ROB_IDX_WIDTH-1:0] out_rob_idx_o
);

    localparam int unsigned CntW = $clog2(XLEN);

    muldiv_state_t            state_q, state_d;
    muldiv_op_t               op_q, op_d, in_op;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [2*XLEN-1:0]        acc_q, acc_d, step_acc;
    logic [XLEN-1:0]          rem_q, rem_d, step_rem;
    logic [XLEN-1:0]          opa_q, opa_d, opb_q, opb_d;
    logic                     neg_q, neg_d;
    logic [XLEN-1:0]          res_q, res_d;
    logic [4:0]               rd_q, rd_d;
    logic [ROB_IDX_WIDTH-1:0] rob_q, rob_d;

    logic                     in_div, busy_div, sign_a, sign_b, b_zero;
    logic [XLEN-1:0]          abs_a, abs_b, final_res;
    logic [2*XLEN-1:0]        raw, fixed;

    always_comb begin
        in_op  = muldiv_op_t'(in_op_i);
        in_div = op_is_div(in_op);
        sign_a = rs1_signed(in_op) & in_rs1_i[XLEN-1];
        sign_b = rs2_signed(in_op) & in_rs2_i[XLEN-1];
        abs_a  = sign_a ? -in_rs1_i : in_rs1_i;
        abs_b  = sign_b ? -in_rs2_i : in_rs2_i;
        b_zero = (in_rs2_i == '0);
    end

`ifdef MULDIV_FASTPATH_EN
    logic            fast_hit, fast_ovf;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        fast_ovf = (in_op inside {OpDiv, OpRem}) && (in_rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                   && (&in_rs2_i);
        fast_hit = 1'b0;
        fast_res = '0;
        if (in_div && b_zero) begin
            fast_hit = 1'b1;
            fast_res = (in_op inside {OpDiv, OpDivu}) ? '1 : in_rs1_i;
        end else if (fast_ovf) begin
            fast_hit = 1'b1;
            fast_res = (in_op == OpDiv) ? in_rs1_i : '0;
        end else if (!in_div && (in_rs1_i == '0 || b_zero)) begin
            fast_hit = 1'b1;
        end
    end
`endif

    assign busy_div = op_is_div(op_q);

    muldiv_fu_step #(
        .XLEN(XLEN)
    ) u_step (
        .is_div_i (busy_div),
        .mbit_i   (opb_q[XLEN-1]),
        .acc_i    (acc_q),
        .rem_i    (rem_q),
        .opnd_i   (opa_q),
        .acc_o    (step_acc),
        .rem_o    (step_rem)
    );

    // Sign fix is applied to a widened magnitude so one negation serves every op.
    always_comb begin
        if (!busy_div) begin
            raw = step_acc;
        end else if (op_q inside {OpDiv, OpDivu}) begin
            raw = {{XLEN{1'b0}}, step_acc[XLEN-1:0]};
        end else begin
            raw = {{XLEN{1'b0}}, step_rem};
        end
        fixed     = neg_q ? -raw : raw;
        final_res = (op_q inside {OpMulh, OpMulhsu, OpMulhu}) ? fixed[2*XLEN-1:XLEN]
                                                              : fixed[XLEN-1:0];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        res_d   = res_q;
        rd_d    = rd_q;
        rob_d   = rob_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    op_d  = in_op;
                    rd_d  = in_rd_addr_i;
                    rob_d = in_rob_idx_i;
                    cnt_d = '0;
                    rem_d = '0;
                    // Divide by zero keeps an all-ones quotient, so never negate it.
                    if (!in_div) begin
                        neg_d = sign_a ^ sign_b;
                    end else if (in_op inside {OpRem, OpRemu}) begin
                        neg_d = sign_a;
                    end else begin
                        neg_d = (sign_a ^ sign_b) & ~b_zero;
                    end
                    if (in_div) begin
                        acc_d = {{XLEN{1'b0}}, abs_a};
                        opa_d = abs_b;
                        opb_d = '0;
                    end else begin
                        acc_d = '0;
                        opa_d = abs_a;
                        opb_d = abs_b;
                    end
                    state_d = StBusy;
`ifdef MULDIV_FASTPATH_EN
                    if (fast_hit) begin
                        res_d   = fast_res;
                        state_d = StDone;
                    end
`endif
                end
            end
            StBusy: begin
                acc_d = step_acc;
                rem_d = step_rem;
                opb_d = opb_q << 1;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(XLEN - 1)) begin
                    res_d   = final_res;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d = StIdle;
            cnt_d   = '0;
            res_d   = '0;
            rd_d    = '0;
            rob_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= OpMul;
            cnt_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            rd_q    <= '0;
            rob_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
            rob_q   <= rob_d;
        end
    end

    // Fields are forced to zero outside the result pulse so the CDB can OR-merge them.
    assign ready_o       = (state_q == StIdle);
    assign out_valid_o   = (state_q == StDone);
    assign out_data_o    = out_valid_o ? res_q : '0;
    assign out_rd_addr_o = out_valid_o ? rd_q : '0;
    assign out_rob_idx_o = out_valid_o ? rob_q : '0;

endmodule

// File: tb/tb_muldiv_fu.sv
// Self-checking bench for muldiv_fu: directed RV32M corner cases, random ops against an
// arithmetic reference model, flush/reset aborts and back-to-back issue with in_valid held high.
module tb_muldiv_fu;

`ifdef MULDIV_FASTPATH_EN
    localparam bit FastPath = 1'b1;
`else
    localparam bit FastPath = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic [2:0]  in_op_i;
    logic [31:0] in_rs1_i;
    logic [31:0] in_rs2_i;
    logic [4:0]  in_rd_addr_i;
    logic [4:0]  in_rob_idx_i;
    logic        ready_o;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic [4:0]  out_rd_addr_o;
    logic [4:0]  out_rob_idx_o;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    muldiv_fu #(
        .XLEN          (32),
        .ROB_IDX_WIDTH (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_op_i       (in_op_i),
        .in_rs1_i      (in_rs1_i),
        .in_rs2_i      (in_rs2_i),
        .in_rd_addr_i  (in_rd_addr_i),
        .in_rob_idx_i  (in_rob_idx_i),
        .ready_o       (ready_o),
        .out_valid_o   (out_valid_o),
        .out_data_o    (out_data_o),
        .out_rd_addr_o (out_rd_addr_o),
        .out_rob_idx_o (out_rob_idx_o)
    );

    always @(negedge clk) if (out_valid_o) pulse_cnt <= pulse_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference: plain 64-bit arithmetic following the RISC-V M-extension rules.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        bit fast;
        fast = (op[2] && b == 0)
            || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            || (!op[2] && (a == 0 || b == 0));
        return (FastPath && fast) ? 1 : 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issues one op and observes the following 40 cycles; comparisons stay with the callers.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [4:0] rob,
                         output bit was_ready, output int lat, output int pulses,
                         output logic [31:0] data, output logic [4:0] ord,
                         output logic [4:0] orob, output bit leak);
        @(negedge clk);
        was_ready    = ready_o;
        in_valid_i   = 1'b1;
        in_op_i      = op;
        in_rs1_i     = a;
        in_rs2_i     = b;
        in_rd_addr_i = rd;
        in_rob_idx_i = rob;
        @(posedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
        lat = 0; pulses = 0; leak = 1'b0; data = '0; ord = '0; orob = '0;
        for (int c = 1; c <= 40; c++) begin
            if (out_valid_o) begin
                pulses++;
                if (pulses == 1) begin
                    lat = c; data = out_data_o; ord = out_rd_addr_o; orob = out_rob_idx_o;
                end
            end else if (out_data_o != 0 || out_rd_addr_o != 0 || out_rob_idx_o != 0) begin
                leak = 1'b1;
            end
            if (c < 40) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b1; in_op_i = 3'd4;
        in_rs1_i = $urandom; in_rs2_i = $urandom; in_rd_addr_i = 5'd7; in_rob_idx_i = 5'd9;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ready_o !== 1'b1) begin errors++;
            $display("FAIL reset ready: got %b expected 1", ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++;
            $display("FAIL reset out_valid: got %b expected 0", out_valid_o); end
        checks++; if (out_data_o !== 32'h0) begin errors++;
            $display("FAIL reset out_data: got %h expected 0", out_data_o); end
        checks++; if (out_rd_addr_o !== 5'h0 || out_rob_idx_o !== 5'h0) begin errors++;
            $display("FAIL reset tags: got rd %h rob %h expected 0", out_rd_addr_o,
                     out_rob_idx_o); end
        rst = 1'b0; in_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (ready_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++;
            $display("FAIL post-reset idle: got ready %b valid %b expected 1 0", ready_o,
                     out_valid_o); end
    endtask

    task automatic test_directed();
        logic [2:0]  t_op  [14];
        logic [31:0] t_a   [14];
        logic [31:0] t_b   [14];
        logic [31:0] t_res [14];
        bit rdy, leak; int lat, pulses; logic [31:0] d; logic [4:0] ord, orob, rob, rd;
        t_op  = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd4, 3'd6, 3'd4, 3'd6, 3'd4,
                  3'd0, 3'd7};
        t_a   = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                  32'hFFFF_FFF9, 32'd7, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9};
        t_b   = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                  32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h1234_5678,
                  32'd0};
        t_res = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                  32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0,
                  32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFF9};
        for (int i = 0; i < 14; i++) begin
            rob = (i == 0) ? 5'd3 : 5'(i + 3);
            rd  = 5'(i + 1);
            do_op(t_op[i], t_a[i], t_b[i], rd, rob, rdy, lat, pulses, d, ord, orob, leak);
            checks++; if (rdy !== 1'b1) begin errors++;
                $display("FAIL directed[%0d] ready: got %b expected 1", i, rdy); end
            checks++; if (d !== t_res[i]) begin errors++;
                $display("FAIL directed[%0d] data: got %h expected %h", i, d, t_res[i]); end
            checks++; if (orob !== rob || ord !== rd) begin errors++;
                $display("FAIL directed[%0d] tags: got rob %0d rd %0d expected %0d %0d", i,
                         orob, ord, rob, rd); end
            checks++; if (lat != exp_lat(t_op[i], t_a[i], t_b[i])) begin errors++;
                $display("FAIL directed[%0d] latency: got %0d expected %0d", i, lat,
                         exp_lat(t_op[i], t_a[i], t_b[i])); end
            checks++; if (pulses != 1 || leak) begin errors++;
                $display("FAIL directed[%0d] pulse: got %0d pulses leak %b expected 1 0", i,
                         pulses, leak); end
        end
    endtask

    task automatic test_random();
        bit rdy, leak; int lat, pulses; logic [31:0] d, a, b, expv;
        logic [4:0] ord, orob, rob, rd; logic [2:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick_operand(); b = pick_operand();
            rd = 5'($urandom); rob = 5'($urandom);
            expv = ref_model(op, a, b);
            do_op(op, a, b, rd, rob, rdy, lat, pulses, d, ord, orob, leak);
            checks++; if (d !== expv) begin errors++;
                $display("FAIL random[%0d] op %0d %h,%h data: got %h expected %h", i, op, a, b,
                         d, expv); end
            checks++; if (orob !== rob || ord !== rd) begin errors++;
                $display("FAIL random[%0d] tags: got rob %0d rd %0d expected %0d %0d", i, orob,
                         ord, rob, rd); end
            checks++; if (lat != exp_lat(op, a, b) || pulses != 1 || leak) begin errors++;
                $display("FAIL random[%0d] timing: got lat %0d pulses %0d leak %b", i, lat,
                         pulses, leak); end
        end
    endtask

    task automatic test_flush();
        bit rdy, leak; int lat, pulses, p0, p1; logic [31:0] d; logic [4:0] ord, orob;
        @(negedge clk);
        in_valid_i = 1'b1; in_op_i = 3'd4; in_rs1_i = 32'd100; in_rs2_i = 32'd7;
        in_rd_addr_i = 5'd9; in_rob_idx_i = 5'd21;
        @(posedge clk);
        p0 = pulse_cnt;
        @(negedge clk);
        in_valid_i = 1'b0;
        repeat (9) @(negedge clk);
        checks++; if (ready_o !== 1'b0) begin errors++;
            $display("FAIL flush busy ready: got %b expected 0", ready_o); end
        flush_i = 1'b1; in_valid_i = 1'b1; in_op_i = 3'd0; in_rob_idx_i = 5'd30;
        @(posedge clk);
        #1 flush_i = 1'b0; in_valid_i = 1'b0;
        do_op(3'd0, 32'd6, 32'd9, 5'd4, 5'd12, rdy, lat, pulses, d, ord, orob, leak);
        @(posedge clk);
        p1 = pulse_cnt;
        checks++; if (rdy !== 1'b1) begin errors++;
            $display("FAIL flush ready after: got %b expected 1", rdy); end
        checks++; if (p1 - p0 != 1) begin errors++;
            $display("FAIL flush pulses: got %0d expected 1", p1 - p0); end
        checks++; if (lat != 33 || d !== 32'd54 || orob !== 5'd12) begin errors++;
            $display("FAIL flush follow-up mul: got lat %0d data %h rob %0d expected 33 36 12",
                     lat, d, orob); end

        // synchronous reset in the middle of an op behaves like a flush
        @(negedge clk);
        in_valid_i = 1'b1; in_op_i = 3'd6; in_rs1_i = 32'd1234; in_rs2_i = 32'd5;
        in_rob_idx_i = 5'd17;
        @(posedge clk);
        p0 = pulse_cnt;
        @(negedge clk);
        in_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (ready_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++;
            $display("FAIL rst mid-op: got ready %b valid %b expected 1 0", ready_o,
                     out_valid_o); end
        repeat (40) @(negedge clk);
        @(posedge clk);
        p1 = pulse_cnt;
        checks++; if (p1 != p0) begin errors++;
            $display("FAIL rst mid-op pulses: got %0d expected 0", p1 - p0); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [5];
        logic [31:0] as  [5];
        logic [31:0] bs  [5];
        logic [31:0] exp_data [$];
        logic [4:0]  exp_rob [$];
        logic [31:0] ed;
        logic [4:0]  er;
        int idx, got, last_issue;
        bit adv;
        idx = 0; got = 0; last_issue = -1;
        for (int i = 0; i < 5; i++) begin
            ops[i] = 3'($urandom_range(0, 7));
            as[i]  = $urandom | 32'h1;
            bs[i]  = $urandom | 32'h1;
        end
        @(negedge clk);
        in_valid_i = 1'b1; in_op_i = ops[0]; in_rs1_i = as[0]; in_rs2_i = bs[0];
        in_rd_addr_i = 5'd1; in_rob_idx_i = 5'd10;
        for (int cyc = 0; cyc < 5 * 34 + 80 && got < 5; cyc++) begin
            if (out_valid_o) begin
                checks++;
                if (exp_data.size() == 0) begin errors++;
                    $display("FAIL b2b unexpected result: got %h expected none", out_data_o);
                end else begin
                    ed = exp_data.pop_front(); er = exp_rob.pop_front();
                    if (out_data_o !== ed || out_rob_idx_o !== er) begin errors++;
                        $display("FAIL b2b result: got %h rob %0d expected %h rob %0d",
                                 out_data_o, out_rob_idx_o, ed, er); end
                end
                got++;
            end
            adv = 1'b0;
            if (ready_o && in_valid_i) begin
                if (last_issue >= 0) begin
                    checks++; if (cyc - last_issue != 34) begin errors++;
                        $display("FAIL b2b issue spacing: got %0d expected 34",
                                 cyc - last_issue); end
                end
                last_issue = cyc;
                exp_data.push_back(ref_model(ops[idx], as[idx], bs[idx]));
                exp_rob.push_back(5'(idx + 10));
                adv = 1'b1;
            end
            @(posedge clk);
            if (adv) begin
                idx++;
                #1;
                if (idx < 5) begin
                    in_op_i = ops[idx]; in_rs1_i = as[idx]; in_rs2_i = bs[idx];
                    in_rd_addr_i = 5'(idx + 1); in_rob_idx_i = 5'(idx + 10);
                end else begin
                    in_valid_i = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        checks++; if (got != 5 || idx != 5) begin errors++;
            $display("FAIL b2b count: got %0d results %0d issues expected 5 5", got, idx); end
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_op_i = '0;
        in_rs1_i = '0; in_rs2_i = '0; in_rd_addr_i = '0; in_rob_idx_i = '0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
